// File: rtl/difftest_uart_arbiter.sv
// rtl/difftest_uart_arbiter.sv - merges per-core UART char streams into one output channel
//
// Purpose:
//   Each port feeds its own FIFO. A round-robin arbiter pops at most one char per cycle
//   into a single output register. With LINE_LOCK set, the grant stays on one port until
//   a '\n' is transferred or that port's FIFO has sat empty for LOCK_TIMEOUT cycles.
//   Overflowing writes are counted in per-port saturating 16-bit drop counters.
//
// Ports:
//   clock      in   clock
//   reset      in   synchronous active-high reset
//   in_valid   in   [NUM_PORTS]     per-port char strobe
//   in_ch      in   [8*NUM_PORTS]   per-port char, port p at [8p+7:8p]
//   out_valid  out  merged char valid
//   out_ch     out  [8] merged char
//   out_ready  in   consumer accepts when out_valid && out_ready
//   out_port   out  source port of out_ch
//   drop_cnt   out  [16*NUM_PORTS]  per-port dropped-char count, port p at [16p+15:16p]
//   busy       out  any FIFO non-empty or out_valid
module difftest_uart_arbiter #(
  parameter int NUM_PORTS    = 4,
  parameter int FIFO_DEPTH   = 16,
  parameter int LINE_LOCK    = 1,
  parameter int LOCK_TIMEOUT = 256
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic [NUM_PORTS-1:0]                             in_valid,
  input  logic [8*NUM_PORTS-1:0]                           in_ch,
  output logic                                             out_valid,
  output logic [7:0]                                       out_ch,
  input  logic                                             out_ready,
  output logic [((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1)-1:0] out_port,
  output logic [16*NUM_PORTS-1:0]                          drop_cnt,
  output logic                                             busy
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [CW-1:0] FULL_COUNT   = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t          state, state_next;
  logic [TW-1:0]   tcnt, tcnt_next;
  logic [PW-1:0]   last_grant;   // also the locked port while in LOCKED

  logic [7:0]      mem    [NUM_PORTS][FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr [NUM_PORTS];
  logic [AW-1:0]   wr_ptr [NUM_PORTS];
  logic [CW-1:0]   count  [NUM_PORTS];
  logic [15:0]     drops  [NUM_PORTS];

  logic [NUM_PORTS-1:0] nonempty, push_en, pop_en;
  logic                 load, timeout_hit, pop_valid;
  logic [PW-1:0]        pop_port, cand;
  logic [7:0]           pop_ch;
  int                   sum;

  // Fullness uses the start-of-cycle count, so a same-cycle pop never frees a slot.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      nonempty[p] = (count[p] != '0);
      push_en[p]  = in_valid[p] && (count[p] != FULL_COUNT);
    end
  end

  always_comb begin
    load        = !out_valid || out_ready;
    // On the last timeout cycle the lock is ignored so another port can win right away.
    timeout_hit = (state == LOCKED) && !nonempty[last_grant] && (tcnt == TIMEOUT_LAST);
    pop_valid   = 1'b0;
    pop_port    = last_grant;
    sum         = 0;
    cand        = '0;
    if (load) begin
      if (state == LOCKED && !timeout_hit) begin
        pop_valid = nonempty[last_grant];
      end else begin
        // Descending scan: the last hit is the nearest port after last_grant.
        for (int i = NUM_PORTS; i >= 1; i--) begin
          sum = int'(last_grant) + i;
          if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
          cand = PW'(sum);
          if (nonempty[cand]) begin
            pop_valid = 1'b1;
            pop_port  = cand;
          end
        end
      end
    end
    pop_ch = mem[pop_port][rd_ptr[pop_port]];

    state_next = state;
    tcnt_next  = tcnt;
    if (pop_valid) begin
      tcnt_next = '0;
      if (LINE_LOCK != 0 && pop_ch != 8'h0A) state_next = LOCKED;
      else                                   state_next = IDLE;
    end else if (state == LOCKED) begin
      if (timeout_hit) begin
        state_next = IDLE;
        tcnt_next  = '0;
      end else if (!nonempty[last_grant]) begin
        tcnt_next = tcnt + TW'(1);
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      pop_en[p] = pop_valid && (pop_port == PW'(p));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      tcnt       <= '0;
      last_grant <= '0;
      out_valid  <= 1'b0;
      out_ch     <= 8'h00;
      out_port   <= '0;
    end else begin
      state <= state_next;
      tcnt  <= tcnt_next;
      if (pop_valid) last_grant <= pop_port;
      if (load) begin
        out_valid <= pop_valid;
        if (pop_valid) begin
          out_ch   <= pop_ch;
          out_port <= pop_port;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (reset) begin
        rd_ptr[p] <= '0;
        wr_ptr[p] <= '0;
        count[p]  <= '0;
        drops[p]  <= 16'h0000;
      end else begin
        if (push_en[p]) wr_ptr[p] <= wr_ptr[p] + AW'(1);
        if (pop_en[p])  rd_ptr[p] <= rd_ptr[p] + AW'(1);
        case ({push_en[p], pop_en[p]})
          2'b10:   count[p] <= count[p] + CW'(1);
          2'b01:   count[p] <= count[p] - CW'(1);
          default: count[p] <= count[p];
        endcase
        if (in_valid[p] && !push_en[p] && drops[p] != 16'hFFFF) drops[p] <= drops[p] + 16'd1;
      end
    end
  end

  // Storage needs no reset: pointers and counts define what is valid.
  always_ff @(posedge clock) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (push_en[p]) mem[p][wr_ptr[p]] <= in_ch[8*p +: 8];
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_drop
    assign drop_cnt[16*g +: 16] = drops[g];
  end

  assign busy = (|nonempty) || out_valid;

endmodule
